dsi_packet_disassembler: RTL and testbench
==========================================

# dsi_packet_disassembler

Receive-side counterpart of the DSI packet assembler: consumes the merged HS byte stream from the lane deskew/merge logic, hunts for the sync byte, then parses DSI packets. It decodes headers with ECC check, streams long-packet payload bytes out, and verifies the payload CRC. It sits between the PHY lane merger and the command/pixel sinks of the panel-side (loopback/test) receiver.

## Interface
- g_check_crc, 1, when 0 the CRC bytes are consumed but `crc_err_o` is held 0
- clk_i  in  1  core clock
- rst_n_i  in  1  reset, asynchronous, active-low
- phy_d_i  in  8  merged HS byte, lane 0 first
- phy_dvalid_i  in  1  `phy_d_i` valid this cycle
- phy_hs_i  in  1  high for the whole HS burst (SoT..EoT)
- h_valid_o  out  1  one-cycle pulse: header fields valid
- h_vc_o  out  2  virtual channel (DI[7:6])
- h_type_o  out  6  data type (DI[5:0])
- h_wcount_o  out  16  word count (long) or command bytes {byte2,byte1} (short)
- h_islong_o  out  1  packet is long
- d_o  out  8  payload byte
- d_valid_o  out  1  payload byte valid
- d_last_o  out  1  with `d_valid_o`: final payload byte
- p_end_o  out  1  one-cycle pulse: long packet complete, CRC checked
- crc_err_o  out  1  qualified by `p_end_o`
- ecc_err_o  out  1  one-cycle pulse: header ECC mismatch
- trunc_err_o  out  1  one-cycle pulse: burst ended inside a packet

## Operation
- No backpressure; every valid input byte is consumed.
- States: ST_HUNT, ST_HEADER, ST_PAYLOAD, ST_CRC, ST_DISCARD.
- ST_HUNT: on `phy_dvalid_i && phy_hs_i && phy_d_i == DSI_SYNC_SEQ` -> ST_HEADER. Other bytes are ignored.
- ST_HEADER: collect DI, WC0, WC1, ECC (2-bit counter).
  - ECC is recomputed by `dsi_parity` over {WC1, WC0, DI}, with DI in d[7:0].
  - Mismatch: pulse `ecc_err_o`, no `h_valid_o`, go to ST_DISCARD. No single-bit correction.
  - Match: pulse `h_valid_o`.
  - Long (type[3:0] in {9, C, D, E}): load the 16-bit byte counter with WC. Go to ST_PAYLOAD, or to ST_CRC when WC = 0.
  - Short: go back to ST_HEADER, which allows back-to-back packets in one burst.
- ST_PAYLOAD: each valid byte goes to `d_o`, is fed to `dsi_crc`, and decrements the counter. At counter = 1, assert `d_last_o` and go to ST_CRC.
- ST_CRC: take CRC LSB, then MSB, and compare with the running CRC. Initial value 0xFFFF, reset on the header's ECC byte, so an empty payload yields 0xFFFF. Pulse `p_end_o` (plus `crc_err_o` on mismatch), then go to ST_HEADER.
- ST_DISCARD: ignore bytes until `phy_hs_i` is low.
- `phy_hs_i` low in any state -> ST_HUNT next cycle. If the state was ST_HEADER with ≥1 byte taken, ST_PAYLOAD, or ST_CRC, pulse `trunc_err_o`; no `p_end_o` is issued. In ST_HEADER with 0 bytes taken, the drop is a clean burst end.
- Trailing EoT bytes that fail ECC produce `ecc_err_o` then ST_DISCARD. This is expected; sinks count it, it is not fatal.

## Timing
- Reset: state ST_HUNT, counters 0, all outputs 0.
- `h_valid_o` and header fields: registered, 1 cycle after the ECC byte is sampled. Fields hold until the next header.
- `d_o`/`d_valid_o`/`d_last_o`: 1-cycle registered latency from `phy_d_i`.
- `p_end_o`/`crc_err_o`: 1 cycle after the CRC MSB is sampled.
- `phy_dvalid_i` gaps stall all counters and hold the state.
- Simultaneous `phy_hs_i` fall and a valid byte: the abort wins and the byte is dropped.
- Reset mid-packet: immediate return to reset values, no error pulses.

## Structure
- Shared in `dsi_defs.vh`:
  - `DSI_SYNC_SEQ` (8'hB8)
  - state encodings
  - `DSI_TYPE_IS_LONG(t)` macro, shared with the assembler-side packet generators
- Instantiates the existing `dsi_parity` and `dsi_crc` (g_max_data_bytes = 1, nbytes_i = 1). No other sub-module is needed.

## Test plan
- Sync 0xB8, then short DCS write: DI 0x05, data 0x11, 0x00, correct ECC -> `h_valid_o` with type 0x05, vc 0, `h_wcount_o` 0x0011, `h_islong_o` 0; no `d_valid_o`.
- Long 0x39, WC 3, payload 0x2C 0xAA 0x55, correct CRC -> 3 `d_valid_o` with `d_last_o` on 0x55; `p_end_o` with `crc_err_o` 0.
- Same packet with CRC LSB bit 0 flipped -> `p_end_o` with `crc_err_o` 1.
- Null long packet 0x09, WC 0, CRC 0xFFFF -> `h_valid_o`, no payload, `p_end_o` with `crc_err_o` 0.
- Header bit flip -> `ecc_err_o`, no `h_valid_o`, and a following valid packet in the same burst is ignored. The next burst decodes normally.
- Long WC 10 with `phy_hs_i` dropped after 4 payload bytes -> 4 `d_valid_o`, `trunc_err_o` pulse, no `p_end_o`. Two short packets back-to-back -> two `h_valid_o` pulses, 4 data cycles apart.

Source files
------------

// File: rtl/dsi_packet_disassembler_pkg.sv
// dsi_packet_disassembler_pkg
//   Shared definitions for the DSI receive-side packet disassembler:
//   the HS sync byte, the parser state encoding and the long-packet
//   data-type classifier, which is shared with the packet generators.
//   No ports (package).
package dsi_packet_disassembler_pkg;

  localparam logic [7:0] DSI_SYNC_SEQ = 8'hB8;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_DISCARD = 3'd4
  } dsi_rx_state_e;

  // Long packets are identified by the low nibble of the data type.
  function automatic logic dsi_type_is_long(input logic [5:0] t);
    return (t[3:0] == 4'h9) || (t[3:0] == 4'hC) ||
           (t[3:0] == 4'hD) || (t[3:0] == 4'hE);
  endfunction

endpackage

// File: rtl/dsi_crc.sv
// dsi_crc
//   Running DSI payload CRC (CRC-16, x^16+x^12+x^5+1, LSB first,
//   seed 0xFFFF). Up to g_max_data_bytes bytes are absorbed per cycle.
//   Ports:
//     clk_i, rst_n_i  clock, asynchronous active-low reset
//     clear_i         reload the seed (wins over en_i)
//     en_i            absorb nbytes_i bytes of data_i this cycle
//     nbytes_i        number of valid bytes, byte 0 in data_i[7:0]
//     data_i          payload bytes
//     crc_o [15:0]    current CRC value
module dsi_crc #(
  parameter int g_max_data_bytes = 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_n_i,
  input  logic                                  clear_i,
  input  logic                                  en_i,
  input  logic [$clog2(g_max_data_bytes+1)-1:0] nbytes_i,
  input  logic [8*g_max_data_bytes-1:0]         data_i,
  output logic [15:0]                           crc_o
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;

  // Reflected polynomial 0x8408, one bit at a time, data LSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  // Next CRC: seed on clear, otherwise fold in the enabled bytes.
  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = 16'hFFFF;
    end else if (en_i) begin
      for (int k = 0; k < g_max_data_bytes; k++) begin
        if (k < int'(nbytes_i)) begin
          crc_d = crc_byte(crc_d, data_i[8*k +: 8]);
        end else begin
          crc_d = crc_d;
        end
      end
    end else begin
      crc_d = crc_q;
    end
  end

  // CRC state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_q <= 16'hFFFF;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/dsi_parity.sv
// dsi_parity
//   DSI packet-header ECC generator (Hamming code over 24 header bits).
//   Ports:
//     data_i [23:0]  {WC1, WC0, DI}, DI in bits [7:0]
//     ecc_o  [7:0]   ECC byte; bits [7:6] are always 0
module dsi_parity (
  input  logic [23:0] data_i,
  output logic [7:0]  ecc_o
);

  // Each ECC bit is the XOR of the header bits selected by its mask.
  localparam logic [23:0] P0_MASK = 24'hF12CB7;
  localparam logic [23:0] P1_MASK = 24'hF2555B;
  localparam logic [23:0] P2_MASK = 24'h749A6D;
  localparam logic [23:0] P3_MASK = 24'hB8E38E;
  localparam logic [23:0] P4_MASK = 24'hDF03F0;
  localparam logic [23:0] P5_MASK = 24'hEFFC00;

  assign ecc_o = {2'b00,
                  ^(data_i & P5_MASK),
                  ^(data_i & P4_MASK),
                  ^(data_i & P3_MASK),
                  ^(data_i & P2_MASK),
                  ^(data_i & P1_MASK),
                  ^(data_i & P0_MASK)};

endmodule

// File: rtl/dsi_packet_disassembler.sv
// dsi_packet_disassembler
//   Receive-side DSI packet parser. Hunts for the HS sync byte in the
//   merged lane stream, checks header ECC, reports header fields,
//   streams long-packet payload bytes and verifies the payload CRC.
//   Ports:
//     clk_i, rst_n_i           clock, asynchronous active-low reset
//     phy_d_i/phy_dvalid_i     merged HS byte and its valid strobe
//     phy_hs_i                 high for the whole HS burst
//     h_valid_o + h_*_o        header pulse and held header fields
//     d_o/d_valid_o/d_last_o   payload byte stream
//     p_end_o/crc_err_o        long packet done, CRC result
//     ecc_err_o, trunc_err_o   header ECC error, burst ended mid-packet
module dsi_packet_disassembler
  import dsi_packet_disassembler_pkg::*;
#(
  parameter bit g_check_crc = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  phy_d_i,
  input  logic        phy_dvalid_i,
  input  logic        phy_hs_i,
  output logic        h_valid_o,
  output logic [1:0]  h_vc_o,
  output logic [5:0]  h_type_o,
  output logic [15:0] h_wcount_o,
  output logic        h_islong_o,
  output logic [7:0]  d_o,
  output logic        d_valid_o,
  output logic        d_last_o,
  output logic        p_end_o,
  output logic        crc_err_o,
  output logic        ecc_err_o,
  output logic        trunc_err_o
);

  dsi_rx_state_e state_q, state_d;
  logic [1:0]  hdr_cnt_q, hdr_cnt_d;
  logic [7:0]  di_q, di_d, wc0_q, wc0_d, wc1_q, wc1_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  crc_lsb_q, crc_lsb_d;
  logic        crc_phase_q, crc_phase_d;

  logic        h_valid_q, h_valid_d;
  logic [1:0]  h_vc_q, h_vc_d;
  logic [5:0]  h_type_q, h_type_d;
  logic [15:0] h_wcount_q, h_wcount_d;
  logic        h_islong_q, h_islong_d;
  logic [7:0]  d_q, d_d;
  logic        d_valid_q, d_valid_d;
  logic        d_last_q, d_last_d;
  logic        p_end_q, p_end_d;
  logic        crc_err_q, crc_err_d;
  logic        ecc_err_q, ecc_err_d;
  logic        trunc_err_q, trunc_err_d;

  logic [7:0]  ecc_calc_s;
  logic [15:0] crc_run_s;
  logic        crc_clear_s;
  logic        crc_en_s;

  dsi_parity u_parity (
    .data_i ({wc1_q, wc0_q, di_q}),
    .ecc_o  (ecc_calc_s)
  );

  dsi_crc #(.g_max_data_bytes(1)) u_crc (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .clear_i  (crc_clear_s),
    .en_i     (crc_en_s),
    .nbytes_i (1'b1),
    .data_i   (phy_d_i),
    .crc_o    (crc_run_s)
  );

  // Parser next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    di_d        = di_q;
    wc0_d       = wc0_q;
    wc1_d       = wc1_q;
    byte_cnt_d  = byte_cnt_q;
    crc_lsb_d   = crc_lsb_q;
    crc_phase_d = crc_phase_q;
    h_valid_d   = 1'b0;
    h_vc_d      = h_vc_q;
    h_type_d    = h_type_q;
    h_wcount_d  = h_wcount_q;
    h_islong_d  = h_islong_q;
    d_d         = d_q;
    d_valid_d   = 1'b0;
    d_last_d    = 1'b0;
    p_end_d     = 1'b0;
    crc_err_d   = 1'b0;
    ecc_err_d   = 1'b0;
    trunc_err_d = 1'b0;
    crc_clear_s = 1'b0;
    crc_en_s    = 1'b0;

    if (!phy_hs_i) begin
      // End of burst overrides any byte arriving in the same cycle.
      state_d     = ST_HUNT;
      hdr_cnt_d   = 2'd0;
      byte_cnt_d  = 16'd0;
      crc_phase_d = 1'b0;
      case (state_q)
        ST_HEADER:          trunc_err_d = (hdr_cnt_q != 2'd0);
        ST_PAYLOAD, ST_CRC: trunc_err_d = 1'b1;
        default:            trunc_err_d = 1'b0;
      endcase
    end else if (phy_dvalid_i) begin
      case (state_q)
        ST_HUNT: begin
          if (phy_d_i == DSI_SYNC_SEQ) begin
            state_d   = ST_HEADER;
            hdr_cnt_d = 2'd0;
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_HEADER: begin
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          case (hdr_cnt_q)
            2'd0:    di_d  = phy_d_i;
            2'd1:    wc0_d = phy_d_i;
            2'd2:    wc1_d = phy_d_i;
            default: begin
              // ECC byte: the payload CRC restarts here for every packet.
              crc_clear_s = 1'b1;
              if (phy_d_i != ecc_calc_s) begin
                ecc_err_d = 1'b1;
                state_d   = ST_DISCARD;
              end else begin
                h_valid_d  = 1'b1;
                h_vc_d     = di_q[7:6];
                h_type_d   = di_q[5:0];
                h_wcount_d = {wc1_q, wc0_q};
                h_islong_d = dsi_type_is_long(di_q[5:0]);
                if (dsi_type_is_long(di_q[5:0])) begin
                  byte_cnt_d  = {wc1_q, wc0_q};
                  crc_phase_d = 1'b0;
                  state_d     = ({wc1_q, wc0_q} == 16'd0) ? ST_CRC : ST_PAYLOAD;
                end else begin
                  state_d = ST_HEADER;
                end
              end
            end
          endcase
        end
        ST_PAYLOAD: begin
          d_d        = phy_d_i;
          d_valid_d  = 1'b1;
          crc_en_s   = 1'b1;
          byte_cnt_d = byte_cnt_q - 16'd1;
          if (byte_cnt_q == 16'd1) begin
            d_last_d = 1'b1;
            state_d  = ST_CRC;
          end else begin
            state_d = ST_PAYLOAD;
          end
        end
        ST_CRC: begin
          if (!crc_phase_q) begin
            crc_lsb_d   = phy_d_i;
            crc_phase_d = 1'b1;
          end else begin
            p_end_d     = 1'b1;
            crc_err_d   = g_check_crc && (crc_run_s != {phy_d_i, crc_lsb_q});
            crc_phase_d = 1'b0;
            state_d     = ST_HEADER;
          end
        end
        ST_DISCARD: state_d = ST_DISCARD;
        default:    state_d = ST_HUNT;
      endcase
    end else begin
      // Valid gap: everything holds.
      state_d = state_q;
    end
  end

  // Parser state and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_HUNT;
      hdr_cnt_q   <= 2'd0;
      di_q        <= 8'd0;
      wc0_q       <= 8'd0;
      wc1_q       <= 8'd0;
      byte_cnt_q  <= 16'd0;
      crc_lsb_q   <= 8'd0;
      crc_phase_q <= 1'b0;
      h_valid_q   <= 1'b0;
      h_vc_q      <= 2'd0;
      h_type_q    <= 6'd0;
      h_wcount_q  <= 16'd0;
      h_islong_q  <= 1'b0;
      d_q         <= 8'd0;
      d_valid_q   <= 1'b0;
      d_last_q    <= 1'b0;
      p_end_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      ecc_err_q   <= 1'b0;
      trunc_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      di_q        <= di_d;
      wc0_q       <= wc0_d;
      wc1_q       <= wc1_d;
      byte_cnt_q  <= byte_cnt_d;
      crc_lsb_q   <= crc_lsb_d;
      crc_phase_q <= crc_phase_d;
      h_valid_q   <= h_valid_d;
      h_vc_q      <= h_vc_d;
      h_type_q    <= h_type_d;
      h_wcount_q  <= h_wcount_d;
      h_islong_q  <= h_islong_d;
      d_q         <= d_d;
      d_valid_q   <= d_valid_d;
      d_last_q    <= d_last_d;
      p_end_q     <= p_end_d;
      crc_err_q   <= crc_err_d;
      ecc_err_q   <= ecc_err_d;
      trunc_err_q <= trunc_err_d;
    end
  end

  assign h_valid_o   = h_valid_q;
  assign h_vc_o      = h_vc_q;
  assign h_type_o    = h_type_q;
  assign h_wcount_o  = h_wcount_q;
  assign h_islong_o  = h_islong_q;
  assign d_o         = d_q;
  assign d_valid_o   = d_valid_q;
  assign d_last_o    = d_last_q;
  assign p_end_o     = p_end_q;
  assign crc_err_o   = crc_err_q;
  assign ecc_err_o   = ecc_err_q;
  assign trunc_err_o = trunc_err_q;

endmodule

// File: tb/tb_dsi_packet_disassembler.sv
// tb_dsi_packet_disassembler
//   Self-checking bench: byte bursts are built from DSI packets, a
//   reference parser over the whole burst predicts the events, and a
//   monitor compares DUT events in order.
module tb_dsi_packet_disassembler;

  localparam logic [7:0] SYNC = 8'hB8;
  // ECC syndrome contributed by each header bit d[0]..d[23].
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic [7:0]  phy_d_i = 8'd0;
  logic        phy_dvalid_i = 1'b0;
  logic        phy_hs_i = 1'b0;
  logic        h_valid_o, h_islong_o, d_valid_o, d_last_o;
  logic        p_end_o, crc_err_o, ecc_err_o, trunc_err_o;
  logic [1:0]  h_vc_o;
  logic [5:0]  h_type_o;
  logic [15:0] h_wcount_o;
  logic [7:0]  d_o;

  dsi_packet_disassembler dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .phy_d_i(phy_d_i),
    .phy_dvalid_i(phy_dvalid_i), .phy_hs_i(phy_hs_i),
    .h_valid_o(h_valid_o), .h_vc_o(h_vc_o), .h_type_o(h_type_o),
    .h_wcount_o(h_wcount_o), .h_islong_o(h_islong_o),
    .d_o(d_o), .d_valid_o(d_valid_o), .d_last_o(d_last_o),
    .p_end_o(p_end_o), .crc_err_o(crc_err_o),
    .ecc_err_o(ecc_err_o), .trunc_err_o(trunc_err_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int dut_ecc_n = 0, dut_trunc_n = 0, exp_ecc_n = 0, exp_trunc_n = 0;
  bit mon_en = 1'b0;
  logic last_crc_err = 1'b0;

  logic [7:0]  burst_q[$];
  logic [24:0] exp_hdr_q[$];
  logic [8:0]  exp_dat_q[$];
  logic        exp_pend_q[$];
  int          hv_cyc_q[$], dv_cyc_q[$], pe_cyc_q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_ecc(input logic [23:0] d);
    logic [5:0] s = 6'd0;
    for (int k = 0; k < 24; k++) if (d[k]) s = s ^ ECC_COL[k];
    return {2'b00, s};
  endfunction

  function automatic logic [15:0] ref_crc(input logic [7:0] q[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (q[k]) begin
      for (int b = 0; b < 8; b++) begin
        if (c[0] ^ q[k][b]) c = (c >> 1) ^ 16'h8408;
        else c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic bit is_long(input logic [5:0] t);
    return t[3:0] inside {4'h9, 4'hC, 4'hD, 4'hE};
  endfunction

  task automatic add_hdr(input logic [7:0] di, input logic [15:0] wc, input int flip);
    logic [31:0] p;
    p = {ref_ecc({wc, di}), wc[15:8], wc[7:0], di};
    if (flip >= 0) p[flip] = ~p[flip];
    for (int k = 0; k < 4; k++) burst_q.push_back(p[8*k +: 8]);
  endtask

  task automatic add_long(input logic [7:0] di, input logic [7:0] pay[$], input bit bad_crc, input int flip);
    logic [15:0] c;
    c = ref_crc(pay);
    if (bad_crc) c[0] = ~c[0];
    add_hdr(di, 16'(pay.size()), flip);
    foreach (pay[k]) burst_q.push_back(pay[k]);
    burst_q.push_back(c[7:0]);
    burst_q.push_back(c[15:8]);
  endtask

  // Reference parser: walks the bytes seen while HS was high.
  task automatic model_burst();
    int n, i;
    logic [7:0]  di;
    logic [15:0] wc;
    logic [7:0]  pay[$];
    n = burst_q.size();
    i = 0;
    while (i < n && burst_q[i] != SYNC) i++;
    if (i >= n) return;
    i++;
    while (1) begin
      if (i == n) return;
      if (n - i < 4) begin exp_trunc_n++; return; end
      di = burst_q[i];
      wc = {burst_q[i+2], burst_q[i+1]};
      if (burst_q[i+3] != ref_ecc({wc, di})) begin exp_ecc_n++; return; end
      exp_hdr_q.push_back({di[7:6], di[5:0], wc, is_long(di[5:0])});
      i += 4;
      if (is_long(di[5:0])) begin
        pay.delete();
        for (int k = 0; k < int'(wc) && i < n; k++) begin
          pay.push_back(burst_q[i]);
          exp_dat_q.push_back({burst_q[i], k == int'(wc) - 1});
          i++;
        end
        if (pay.size() < int'(wc) || n - i < 2) begin exp_trunc_n++; return; end
        exp_pend_q.push_back({burst_q[i+1], burst_q[i]} != ref_crc(pay));
        i += 2;
      end
    end
  endtask

  task automatic drive_bytes(input bit gaps);
    @(posedge clk_i); #1;
    phy_hs_i = 1'b1; phy_dvalid_i = 1'b0;
    foreach (burst_q[k]) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          phy_dvalid_i = 1'b0; phy_d_i = 8'($urandom);
          @(posedge clk_i); #1;
        end
      end
      phy_dvalid_i = 1'b1; phy_d_i = burst_q[k];
      @(posedge clk_i); #1;
    end
  endtask

  // One burst end to end: predict, drive, drop HS (maybe with a dropped byte), compare.
  task automatic run_burst(input bit gaps);
    model_burst();
    drive_bytes(gaps);
    phy_hs_i = 1'b0; phy_dvalid_i = 1'($urandom_range(0, 1)); phy_d_i = 8'($urandom);
    @(posedge clk_i); #1;
    phy_dvalid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    chk("hdr_left", 64'(exp_hdr_q.size()), 64'd0);
    chk("dat_left", 64'(exp_dat_q.size()), 64'd0);
    chk("pend_left", 64'(exp_pend_q.size()), 64'd0);
    chk("ecc_cnt", 64'(dut_ecc_n), 64'(exp_ecc_n));
    chk("trunc_cnt", 64'(dut_trunc_n), 64'(exp_trunc_n));
  endtask

  task automatic clear_cyc();
    hv_cyc_q.delete(); dv_cyc_q.delete(); pe_cyc_q.delete();
  endtask

  task automatic gen_random_burst();
    logic [7:0] di, pay[$];
    logic [5:0] t;
    int kind, len;
    burst_q.delete();
    repeat ($urandom_range(0, 2)) burst_q.push_back(8'($urandom));
    burst_q.push_back(SYNC);
    repeat ($urandom_range(1, 4)) begin
      kind = $urandom_range(0, 9);
      if (kind < 4 || kind > 7) begin
        do t = 6'($urandom); while (is_long(t));
        add_hdr({2'($urandom), t}, 16'($urandom), (kind > 7) ? int'($urandom_range(0, 31)) : -1);
      end else begin
        pay.delete();
        repeat ($urandom_range(0, 12)) pay.push_back(8'($urandom));
        case ($urandom_range(0, 3))
          0: t = 6'h09;
          1: t = 6'h0C;
          2: t = 6'h0D;
          default: t = 6'h0E;
        endcase
        t[5:4] = 2'($urandom);
        di = {2'($urandom), t};
        add_long(di, pay, kind == 7, -1);
      end
    end
    if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) burst_q.push_back(8'($urandom));
    if ($urandom_range(0, 2) == 0) begin
      len = $urandom_range(1, burst_q.size() - 1);
      while (burst_q.size() > len) void'(burst_q.pop_back());
    end
  endtask

  initial cyc = 0;
  initial forever begin @(posedge clk_i); cyc++; end

  // Monitor: compares DUT events against the predicted queues.
  initial forever begin
    @(negedge clk_i);
    if (rst_n_i) begin
      if (h_valid_o) begin
        hv_cyc_q.push_back(cyc);
        if (mon_en) begin
          if (exp_hdr_q.size() == 0) chk("hdr_extra", 64'd1, 64'd0);
          else chk("hdr", 64'({h_vc_o, h_type_o, h_wcount_o, h_islong_o}), 64'(exp_hdr_q.pop_front()));
        end
      end
      if (d_valid_o) begin
        dv_cyc_q.push_back(cyc);
        if (mon_en) begin
          if (exp_dat_q.size() == 0) chk("dat_extra", 64'd1, 64'd0);
          else chk("dat", 64'({d_o, d_last_o}), 64'(exp_dat_q.pop_front()));
        end
      end
      if (p_end_o) begin
        pe_cyc_q.push_back(cyc);
        last_crc_err = crc_err_o;
        if (mon_en) begin
          if (exp_pend_q.size() == 0) chk("pend_extra", 64'd1, 64'd0);
          else chk("crc_err", 64'(crc_err_o), 64'(exp_pend_q.pop_front()));
        end
      end
      if (ecc_err_o) dut_ecc_n++;
      if (trunc_err_o) dut_trunc_n++;
    end
  end

  initial begin
    logic [7:0] pay[$];
    int trunc_before;

    // Reset state.
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_hdr", 64'({h_valid_o, h_vc_o, h_type_o, h_wcount_o, h_islong_o}), 64'd0);
    chk("rst_dat", 64'({d_o, d_valid_o, d_last_o, p_end_o, crc_err_o, ecc_err_o, trunc_err_o}), 64'd0);
    rst_n_i = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(posedge clk_i);

    // Short DCS write.
    burst_q.delete(); burst_q.push_back(SYNC); add_hdr(8'h05, 16'h0011, -1);
    clear_cyc(); run_burst(1'b0);
    chk("dcs_type", 64'(h_type_o), 64'h05);
    chk("dcs_vc", 64'(h_vc_o), 64'd0);
    chk("dcs_wc", 64'(h_wcount_o), 64'h0011);
    chk("dcs_long", 64'(h_islong_o), 64'd0);
    chk("dcs_nodata", 64'(dv_cyc_q.size()), 64'd0);

    // Long 0x39, WC 3, good CRC: latency relative to h_valid.
    pay = '{8'h2C, 8'hAA, 8'h55};
    burst_q.delete(); burst_q.push_back(SYNC); add_long(8'h39, pay, 1'b0, -1);
    clear_cyc(); run_burst(1'b0);
    chk("long_ndata", 64'(dv_cyc_q.size()), 64'd3);
    chk("long_crc_ok", 64'(last_crc_err), 64'd0);
    if (hv_cyc_q.size() == 1 && dv_cyc_q.size() == 3 && pe_cyc_q.size() == 1) begin
      chk("d_latency", 64'(dv_cyc_q[0] - hv_cyc_q[0]), 64'd1);
      chk("pend_latency", 64'(pe_cyc_q[0] - hv_cyc_q[0]), 64'd5);
    end else begin
      chk("long_events", 64'({hv_cyc_q.size(), pe_cyc_q.size()}), 64'({32'd1, 32'd1}));
    end

    // Same packet with CRC LSB bit 0 flipped.
    burst_q.delete(); burst_q.push_back(SYNC); add_long(8'h39, pay, 1'b1, -1);
    clear_cyc(); run_burst(1'b0);
    chk("bad_crc_flag", 64'(last_crc_err), 64'd1);

    // Null long packet.
    pay.delete();
    burst_q.delete(); burst_q.push_back(SYNC); add_long(8'h09, pay, 1'b0, -1);
    clear_cyc(); run_burst(1'b0);
    chk("null_pend", 64'(pe_cyc_q.size()), 64'd1);
    chk("null_crc_ok", 64'(last_crc_err), 64'd0);
    chk("null_nodata", 64'(dv_cyc_q.size()), 64'd0);

    // Header bit flip, then a valid packet in the same burst is ignored.
    burst_q.delete(); burst_q.push_back(SYNC); add_hdr(8'h05, 16'h0011, 9);
    add_hdr(8'h15, 16'h3344, -1);
    clear_cyc(); run_burst(1'b0);
    chk("flip_nohdr", 64'(hv_cyc_q.size()), 64'd0);
    burst_q.delete(); burst_q.push_back(SYNC); add_hdr(8'h15, 16'h3344, -1);
    clear_cyc(); run_burst(1'b0);
    chk("after_flip_hdr", 64'(hv_cyc_q.size()), 64'd1);

    // Long WC 10 truncated after 4 payload bytes.
    pay.delete();
    for (int k = 0; k < 10; k++) pay.push_back(8'(k + 1));
    burst_q.delete(); burst_q.push_back(SYNC); add_long(8'h39, pay, 1'b0, -1);
    while (burst_q.size() > 9) void'(burst_q.pop_back());
    trunc_before = dut_trunc_n;
    clear_cyc(); run_burst(1'b0);
    chk("trunc_ndata", 64'(dv_cyc_q.size()), 64'd4);
    chk("trunc_pulse", 64'(dut_trunc_n - trunc_before), 64'd1);
    chk("trunc_nopend", 64'(pe_cyc_q.size()), 64'd0);

    // Two short packets back to back.
    burst_q.delete(); burst_q.push_back(SYNC);
    add_hdr(8'h05, 16'h0011, -1); add_hdr(8'h45, 16'h0029, -1);
    clear_cyc(); run_burst(1'b0);
    if (hv_cyc_q.size() == 2) chk("b2b_spacing", 64'(hv_cyc_q[1] - hv_cyc_q[0]), 64'd4);
    else chk("b2b_count", 64'(hv_cyc_q.size()), 64'd2);

    // Reset in the middle of a long packet.
    mon_en = 1'b0;
    burst_q.delete(); burst_q.push_back(SYNC); add_long(8'h39, pay, 1'b0, -1);
    while (burst_q.size() > 7) void'(burst_q.pop_back());
    trunc_before = dut_trunc_n;
    drive_bytes(1'b0);
    phy_dvalid_i = 1'b0;
    rst_n_i = 1'b0;
    @(negedge clk_i);
    chk("mid_rst_hdr", 64'({h_valid_o, h_vc_o, h_type_o, h_wcount_o, h_islong_o}), 64'd0);
    chk("mid_rst_dat", 64'({d_o, d_valid_o, d_last_o, p_end_o, crc_err_o, ecc_err_o, trunc_err_o}), 64'd0);
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    phy_hs_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("mid_rst_notrunc", 64'(dut_trunc_n - trunc_before), 64'd0);
    mon_en = 1'b1;

    // Randomized bursts with valid gaps.
    for (int r = 0; r < 150; r++) begin
      gen_random_burst();
      run_burst(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
